// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite pixel sources.
package sprite_pkg;

  localparam int COORD_W  = 11;
  localparam int PERIOD_W = 8;

  typedef logic signed [COORD_W:0] rel_coord_t;

endpackage

// File: rtl/sprite_ram_sync.sv
// Simple dual-port sprite image RAM: one write port, one registered read-first read port.
module sprite_ram_sync #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Same-address read and write in one cycle return the stored (old) word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_w] <= din;
    end
    dout <= mem[addr_r];
  end

endmodule

// File: rtl/sprite_anim_src.sv
// Animated sprite pixel source: frame-synchronous shadowed origin/flip/scale,
// animation frame counter and a two-stage RAM lookup pipeline.
module sprite_anim_src
  import sprite_pkg::*;
#(
  parameter int             CD         = 12,
  parameter int             H_SIZE     = 64,
  parameter int             V_SIZE     = 64,
  parameter int             NUM_FRAMES = 4,
  parameter logic [CD-1:0]  KEY_COLOR  = '0,
  localparam int            HW         = $clog2(H_SIZE),
  localparam int            VW         = $clog2(V_SIZE),
  localparam int            FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int            ADDR       = FW + VW + HW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  input  logic                hflip,
  input  logic                scale2,
  input  logic                anim_en,
  input  logic [PERIOD_W-1:0] frame_period,
  input  logic                frame_start,
  input  logic                we,
  input  logic [ADDR-1:0]     addr_w,
  input  logic [CD-1:0]       pixel_in,
  output logic [CD-1:0]       sprite_rgb,
  output logic [FW-1:0]       frame_idx
);

  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);

  logic [COORD_W-1:0]  x0_a, y0_a;
  logic                hflip_a, scale2_a;
  logic [PERIOD_W-1:0] tick_cnt;
  rel_coord_t          xr, yr;
  logic                in_region, in_region_d1;
  logic [HW-1:0]       col_raw, col;
  logic [VW-1:0]       row;
  logic [ADDR-1:0]     addr_r;
  logic [CD-1:0]       ram_dout;

  // Placement attributes only change at frame boundaries so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_a     <= '0;
      y0_a     <= '0;
      hflip_a  <= 1'b0;
      scale2_a <= 1'b0;
    end else if (frame_start) begin
      x0_a     <= x0;
      y0_a     <= y0;
      hflip_a  <= hflip;
      scale2_a <= scale2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      frame_idx <= '0;
    end else if (!anim_en) begin
      tick_cnt  <= '0;
    end else if (frame_start) begin
      if (tick_cnt == frame_period) begin
        tick_cnt  <= '0;
        frame_idx <= (frame_idx == LAST_FRAME) ? '0 : frame_idx + FW'(1);
      end else begin
        tick_cnt  <= tick_cnt + PERIOD_W'(1);
      end
    end
  end

  assign xr = $signed({1'b0, x}) - $signed({1'b0, x0_a});
  assign yr = $signed({1'b0, y}) - $signed({1'b0, y0_a});

  assign in_region = ~xr[COORD_W] & ~yr[COORD_W]
                   & (int'(xr) < (scale2_a ? 2 * H_SIZE : H_SIZE))
                   & (int'(yr) < (scale2_a ? 2 * V_SIZE : V_SIZE));

  // In 2x mode the LSB of the relative coordinate is dropped so each texel covers 2x2 pixels.
  assign col_raw = scale2_a ? xr[HW:1] : xr[HW-1:0];
  assign col     = hflip_a ? ~col_raw : col_raw;
  assign row     = scale2_a ? yr[VW:1] : yr[VW-1:0];
  assign addr_r  = {frame_idx, row, col};

  sprite_ram_sync #(
    .ADDR_WIDTH (ADDR),
    .DATA_WIDTH (CD)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .addr_w (addr_w),
    .din    (pixel_in),
    .addr_r (addr_r),
    .dout   (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_region_d1 <= 1'b0;
      sprite_rgb   <= KEY_COLOR;
    end else begin
      in_region_d1 <= in_region;
      sprite_rgb   <= in_region_d1 ? ram_dout : KEY_COLOR;
    end
  end

endmodule

// File: tb/tb_sprite_anim_src.sv
// Self-checking bench for sprite_anim_src: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural pixel/animation model.
module tb_sprite_anim_src;

  localparam int           CD   = 12;
  localparam int           ADDR = 14;
  localparam logic [11:0]  KEY  = 12'h000;

  logic            clk;
  logic            reset;
  logic [10:0]     x, y, x0, y0;
  logic            hflip, scale2, anim_en, frame_start, we;
  logic [7:0]      frame_period;
  logic [ADDR-1:0] addr_w;
  logic [CD-1:0]   pixel_in;
  logic [CD-1:0]   sprite_rgb;
  logic [1:0]      frame_idx;

  sprite_anim_src #(
    .CD(CD), .H_SIZE(64), .V_SIZE(64), .NUM_FRAMES(4), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .x0(x0), .y0(y0),
    .hflip(hflip), .scale2(scale2), .anim_en(anim_en), .frame_period(frame_period),
    .frame_start(frame_start), .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
    .sprite_rgb(sprite_rgb), .frame_idx(frame_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: image memory plus the attributes in effect for the next lookup.
  logic [11:0] mem [16384];
  int          m_x0, m_y0, m_frame, m_tick;
  bit          m_hflip, m_scale, known, prev_valid;
  logic [11:0] prev_exp;
  int          checks, errors;

  typedef struct {
    logic [10:0] vx0, vy0, vx, vy;
    logic        vflip, vscale, exp_key;
    int          exp_addr;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [11:0] modelPixel(int xi, int yi);
    int dx = xi - m_x0;
    int dy = yi - m_y0;
    int sc = m_scale ? 2 : 1;
    int col, row;
    if (dx < 0 || dy < 0 || dx >= 64 * sc || dy >= 64 * sc) return KEY;
    col = dx / sc;
    row = dy / sc;
    if (m_hflip) col = 63 - col;
    return mem[m_frame * 4096 + row * 64 + col];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the currently driven inputs; the model advances alongside.
  task automatic applyStimulus();
    logic [11:0] exp_now;
    exp_now = reset ? KEY : modelPixel(int'(x), int'(y));
    if (we) mem[addr_w] = pixel_in;
    if (reset) begin
      m_x0 = 0; m_y0 = 0; m_hflip = 0; m_scale = 0;
      m_frame = 0; m_tick = 0; known = 1;
    end else begin
      if (frame_start) begin
        m_x0 = int'(x0); m_y0 = int'(y0); m_hflip = hflip; m_scale = scale2;
      end
      if (!anim_en) m_tick = 0;
      else if (frame_start) begin
        if (m_tick == int'(frame_period)) begin
          m_tick  = 0;
          m_frame = (m_frame + 1) % 4;
        end else m_tick = (m_tick + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      checkOutput("reset_rgb", sprite_rgb, KEY);
      prev_valid = 1;
    end else if (prev_valid) begin
      checkOutput("pixel", sprite_rgb, prev_exp);
    end
    if (known) checkOutput("frame_idx", frame_idx, m_frame);
    prev_exp = exp_now;
  endtask

  initial begin
    logic [11:0] old_px, new_px;
    checks = 0; errors = 0; known = 0; prev_valid = 0;
    reset = 1; x = 11'd2047; y = 11'd2047; x0 = 0; y0 = 0;
    hflip = 0; scale2 = 0; anim_en = 0; frame_period = 0; frame_start = 0;
    we = 0; addr_w = 0; pixel_in = 0;

    vecs[0]  = '{100, 100,  99, 100, 0, 0, 1, 0};
    vecs[1]  = '{100, 100, 100, 100, 0, 0, 0, 0};
    vecs[2]  = '{100, 100, 163, 100, 0, 0, 0, 63};
    vecs[3]  = '{100, 100, 164, 100, 0, 0, 1, 0};
    vecs[4]  = '{100, 100, 130, 110, 0, 0, 0, 670};
    vecs[5]  = '{100, 100, 100, 100, 1, 0, 0, 63};
    vecs[6]  = '{100, 100, 163, 100, 1, 0, 0, 0};
    vecs[7]  = '{  0,   0,   0,   0, 0, 1, 0, 0};
    vecs[8]  = '{  0,   0,   1,   0, 0, 1, 0, 0};
    vecs[9]  = '{  0,   0, 127, 127, 0, 1, 0, 4095};
    vecs[10] = '{  0,   0, 128,   0, 0, 1, 1, 0};
    vecs[11] = '{  0,   0,   0, 128, 0, 1, 1, 0};
    vecs[12] = '{100, 100, 100,  99, 0, 0, 1, 0};

    applyStimulus();
    applyStimulus();
    reset = 0;

    for (int a = 0; a < 16384; a++) begin
      we = 1; addr_w = ADDR'(a); pixel_in = 12'($urandom_range(1, 4095));
      applyStimulus();
    end
    we = 0;

    for (int f = 0; f < 2; f++) begin
      x0 = 100; y0 = 100; hflip = f[0]; scale2 = 0; frame_start = 1;
      applyStimulus();
      frame_start = 0; y = 100;
      for (int xx = 99; xx <= 164; xx++) begin
        x = 11'(xx);
        applyStimulus();
      end
      x = 11'd2047;
      applyStimulus();
      applyStimulus();
    end

    for (int i = 0; i < 13; i++) begin
      x0 = vecs[i].vx0; y0 = vecs[i].vy0; hflip = vecs[i].vflip; scale2 = vecs[i].vscale;
      frame_start = 1;
      applyStimulus();
      frame_start = 0; x = vecs[i].vx; y = vecs[i].vy;
      applyStimulus();
      x = 11'd2047;
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), sprite_rgb,
                  vecs[i].exp_key ? KEY : mem[vecs[i].exp_addr]);
    end

    reset = 1;
    applyStimulus();
    reset = 0; anim_en = 1; frame_period = 2;
    applyStimulus();
    for (int p = 1; p <= 12; p++) begin
      frame_start = 1;
      applyStimulus();
      frame_start = 0;
      checkOutput($sformatf("anim_pulse%0d", p), frame_idx, (p / 3) % 4);
      applyStimulus();
    end

    anim_en = 0; x0 = 100; y0 = 100; hflip = 0; scale2 = 0; frame_start = 1;
    applyStimulus();
    frame_start = 0; x0 = 0; x = 100; y = 100;
    applyStimulus();
    x = 11'd2047;
    applyStimulus();
    checkOutput("old_origin", sprite_rgb, mem[0]);
    frame_start = 1;
    applyStimulus();
    frame_start = 0; x = 5;
    applyStimulus();
    x = 11'd2047;
    applyStimulus();
    checkOutput("new_origin", sprite_rgb, mem[5]);

    anim_en = 1; frame_period = 0; frame_start = 1;
    applyStimulus();
    frame_start = 0; anim_en = 0; x = 10; y = 100;
    applyStimulus();
    applyStimulus();
    reset = 1;
    applyStimulus();
    checkOutput("reset_mid_rgb", sprite_rgb, KEY);
    checkOutput("reset_mid_frame", frame_idx, 0);
    reset = 0;
    applyStimulus();
    checkOutput("reset_release_key", sprite_rgb, KEY);

    x = 7; y = 3;
    old_px = mem[199];
    new_px = (old_px == 12'hABC) ? 12'h123 : 12'hABC;
    we = 1; addr_w = 14'd199; pixel_in = new_px;
    applyStimulus();
    we = 0;
    applyStimulus();
    checkOutput("rw_old", sprite_rgb, old_px);
    x = 11'd2047;
    applyStimulus();
    checkOutput("rw_new", sprite_rgb, new_px);

    for (int n = 0; n < 3000; n++) begin
      x  = 11'($urandom_range(0, 511));
      y  = 11'($urandom_range(0, 511));
      x0 = 11'($urandom_range(0, 300));
      y0 = 11'($urandom_range(0, 300));
      hflip = 1'($urandom_range(0, 1));
      scale2 = 1'($urandom_range(0, 1));
      frame_start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) anim_en = ~anim_en;
      if ($urandom_range(0, 49) == 0) frame_period = 8'($urandom_range(0, 3));
      we = ($urandom_range(0, 7) == 0);
      addr_w = ADDR'($urandom_range(0, 16383));
      pixel_in = 12'($urandom_range(1, 4095));
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    reset = 0; we = 0; frame_start = 0; x = 11'd2047; y = 11'd2047;
    applyStimulus();
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
